mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main controller FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU control code and datapath mux/enable strobes.
- Consumes the ALU Zero flag to resolve branches and a memory ready handshake to stall.
- Sits between instruction register decode fields and the shared-ALU multicycle datapath.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  opcode field, IR[31:26].
- Funct  in  6  function field, IR[5:0].
- Zero  in  1  ALU result-is-zero flag, same cycle as ALUControl.
- MemReady  in  1  memory access completes this cycle.
- ALUControl  out  3  000 passA, 001 AND, 010 XOR, 011 OR, 100 decA, 101 ADD, 110 SUB, 111 incA.
- ALUSrcA  out  1  0 = PC, 1 = regA.
- ALUSrcB  out  2  00 = regB, 01 = const 4, 10 = immediate, 11 = signext(imm)<<2.
- ImmZeroExt  out  1  1 = zero-extend immediate, 0 = sign-extend.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- Illegal  out  1  sticky flag set on an undecodable instruction.
- InstrCount  out  CNT_W  retired-instruction count.

Behaviour:
- Default value of every control output is 0 (ALUControl 000) unless listed for the current state.
- State register updates on the rising clk edge.
- Outputs are Moore, except PCEn and IRWrite in FETCH and PCEn in BRANCH.
- reset (async): state goes to FETCH; all outputs 0; InstrCount = 0; Illegal = 0. Reset mid-instruction abandons it with no writes.
- FETCH:
  - IorD = 0; ALUSrcA = 0; ALUSrcB = 01; ALUControl = 101; PCSrc = 00.
  - IRWrite = PCEn = MemReady.
  - Stay in FETCH while MemReady = 0, else go to DECODE.
- DECODE: ALUSrcA = 0; ALUSrcB = 11; ALUControl = 101 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 -> EXEC if Funct is in {100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor}, else illegal.
  - 000100 (beq) or 000101 (bne) -> BRANCH.
  - 001000 (addi), 001100 (andi), 001101 (ori), 001110 (xori) -> IMMEXEC.
  - 000010 (j) -> JUMP.
  - Any other value is illegal: set Illegal, go to FETCH, no count.
- MEMADR: ALUSrcA = 1; ALUSrcB = 10; ALUControl = 101. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1. Wait for MemReady, then go to MEMWB.
- MEMWB: RegDst = 0; MemtoReg = 1; RegWrite = 1. Go to FETCH.
- MEMWR: IorD = 1; MemWrite = 1, held until the MemReady cycle inclusive. Then go to FETCH.
- EXEC: ALUSrcA = 1; ALUSrcB = 00; ALUControl from Funct: add 101, sub 110, and 001, or 011, xor 010. Go to ALUWB.
- ALUWB: RegDst = 1; MemtoReg = 0; RegWrite = 1. Go to FETCH.
- BRANCH:
  - ALUSrcA = 1; ALUSrcB = 00; ALUControl = 110; PCSrc = 01.
  - PCEn = Zero for beq, ~Zero for bne.
  - Go to FETCH.
- IMMEXEC:
  - ALUSrcA = 1; ALUSrcB = 10.
  - ALUControl: addi 101, andi 001, ori 011, xori 010.
  - ImmZeroExt = 1 for andi, ori, xori; 0 for addi.
  - Go to IMMWB.
- IMMWB: RegDst = 0; MemtoReg = 0; RegWrite = 1. Go to FETCH.
- JUMP: PCSrc = 10; PCEn = 1. Go to FETCH.
- InstrCount increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IMMWB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Illegal aborts and memory stalls do not count.
- Illegal stays set until reset; execution continues with the next fetch.
- Cycle counts with MemReady always 1: lw 5, sw 4, R-type 4, immediate 4, branch 3, jump 3.

Test Plan:
- Reset, hold MemReady = 1:
  - reset high mid-MEMRD -> next edge state FETCH.
  - All strobes 0, InstrCount = 0, Illegal = 0.
  - ALUControl = 101 and PCEn = 1 in the first cycle after release.
- R-type sub (Op 000000, Funct 100010):
  - EXEC shows ALUControl = 110, ALUSrcB = 00.
  - ALUWB shows RegWrite = 1, RegDst = 1.
  - 4 cycles total; InstrCount = 1.
- lw with MemReady low for 3 cycles in MEMRD:
  - IorD = 1 held for 4 cycles; MEMWB asserts MemtoReg = 1, RegWrite = 1.
  - 8 cycles total; count +1.
- beq with Zero = 1 -> PCEn = 1, PCSrc = 01. bne with Zero = 1 -> PCEn = 0. Both count.
- andi (001100) -> ALUControl = 001, ImmZeroExt = 1, then RegWrite with RegDst = 0.
- Op 111111, then Funct 000000 with Op 000000:
  - Each sets Illegal, returns to FETCH after DECODE.
  - InstrCount unchanged; Illegal stays 1 through a following j.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback,
// drives ALU code and datapath strobes, counts retired instructions, flags illegal opcodes.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [2:0]       ALUControl,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ImmZeroExt,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_IMMEXEC, S_IMMWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t     state;
    logic       is_mem, is_rtype, is_branch, is_imm, is_jump;
    logic [2:0] r_alu, i_alu;

    always_comb begin
        is_mem    = (Op == OP_LW) || (Op == OP_SW);
        is_branch = (Op == OP_BEQ) || (Op == OP_BNE);
        is_imm    = (Op == OP_ADDI) || (Op == OP_ANDI) || (Op == OP_ORI) || (Op == OP_XORI);
        is_jump   = (Op == OP_J);
        is_rtype  = 1'b0;
        r_alu     = 3'b000;
        case (Funct)
            6'b100000: begin is_rtype = (Op == OP_R); r_alu = 3'b101; end
            6'b100010: begin is_rtype = (Op == OP_R); r_alu = 3'b110; end
            6'b100100: begin is_rtype = (Op == OP_R); r_alu = 3'b001; end
            6'b100101: begin is_rtype = (Op == OP_R); r_alu = 3'b011; end
            6'b100110: begin is_rtype = (Op == OP_R); r_alu = 3'b010; end
            default:   begin is_rtype = 1'b0;         r_alu = 3'b000; end
        endcase
        case (Op)
            OP_ANDI: i_alu = 3'b001;
            OP_ORI:  i_alu = 3'b011;
            OP_XORI: i_alu = 3'b010;
            default: i_alu = 3'b101;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            Illegal    <= 1'b0;
            InstrCount <= '0;
        end else begin
            case (state)
                S_FETCH:   if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    if (is_mem)         state <= S_MEMADR;
                    else if (is_rtype)  state <= S_EXEC;
                    else if (is_branch) state <= S_BRANCH;
                    else if (is_imm)    state <= S_IMMEXEC;
                    else if (is_jump)   state <= S_JUMP;
                    else begin
                        Illegal <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_MEMADR:  state <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (MemReady) state <= S_MEMWB;
                S_MEMWR: begin
                    if (MemReady) begin
                        state      <= S_FETCH;
                        InstrCount <= InstrCount + 1'b1;
                    end
                end
                S_EXEC:    state <= S_ALUWB;
                S_IMMEXEC: state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: begin
                    state      <= S_FETCH;
                    InstrCount <= InstrCount + 1'b1;
                end
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Decoded from the state register; forced quiet while reset is held.
    always_comb begin
        ALUControl = 3'b000;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmZeroExt = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ALUSrcB = 2'b01; ALUControl = 3'b101;
                    IRWrite = MemReady; PCEn = MemReady;
                end
                S_DECODE:  begin ALUSrcB = 2'b11; ALUControl = 3'b101; end
                S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = 3'b101; end
                S_MEMRD:   IorD = 1'b1;
                S_MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
                S_MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; end
                S_EXEC:    begin ALUSrcA = 1'b1; ALUControl = r_alu; end
                S_ALUWB:   begin RegDst = 1'b1; RegWrite = 1'b1; end
                S_BRANCH: begin
                    ALUSrcA = 1'b1; ALUControl = 3'b110; PCSrc = 2'b01;
                    PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
                end
                S_IMMEXEC: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = i_alu;
                    ImmZeroExt = (Op != OP_ADDI);
                end
                S_IMMWB:   RegWrite = 1'b1;
                S_JUMP:    begin PCSrc = 2'b10; PCEn = 1'b1; end
                default:   ;
            endcase
        end
    end

endmodule
